// File: rtl/id_pkg.sv
// Shared decode constants and the register-usage record for the ID issue buffer.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic       regwrite;
        logic [4:0] dest;
    } reg_use_t;

endpackage

// File: rtl/reg_use_decode.sv
// Combinational extraction of source/destination register usage from a MIPS-I instruction.
module reg_use_decode
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output reg_use_t    use_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    always_comb begin
        use_o = '0;
        if (opcode == OP_SPECIAL) begin
            use_o.uses_rs = 1'b1;
            if (funct == FN_JR) begin
                use_o.regwrite = 1'b0;
            end else if (funct == FN_JALR) begin
                use_o.regwrite = 1'b1;
                use_o.dest     = rd;
            end else begin
                use_o.uses_rt  = 1'b1;
                use_o.regwrite = 1'b1;
                use_o.dest     = rd;
            end
        end else if (opcode == OP_REGIMM) begin
            use_o.uses_rs = 1'b1;
            // BLTZAL/BGEZAL link into r31
            if (rt[4]) begin
                use_o.regwrite = 1'b1;
                use_o.dest     = REG_RA;
            end
        end else if (opcode == OP_JAL) begin
            use_o.regwrite = 1'b1;
            use_o.dest     = REG_RA;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            use_o.uses_rs = 1'b1;
            use_o.uses_rt = 1'b1;
        end else if (opcode == OP_BLEZ || opcode == OP_BGTZ) begin
            use_o.uses_rs = 1'b1;
        end else if (opcode[5:3] == 3'b001 || opcode[5:3] == 3'b100) begin
            // I-type ALU and loads (OP_LW included) write rt
            use_o.uses_rs  = 1'b1;
            use_o.regwrite = 1'b1;
            use_o.dest     = rt;
        end else if (opcode[5:3] == 3'b101) begin
            // stores (OP_SW included)
            use_o.uses_rs = 1'b1;
            use_o.uses_rt = 1'b1;
        end
    end

endmodule

// File: rtl/id_issue_buffer.sv
// IF->ID instruction buffer with a per-register pending-write scoreboard gating issue.
// Optional macro ID_WB_BYPASS_EN lets a source clear in the same cycle as its final WB write.
module id_issue_buffer
    import id_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_dest,
    output logic             out_regwrite,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic             flush,
    input  logic             except_flush,
    output logic [PTR_W:0]   count,
    output logic             stall_hazard,
    output logic             sb_err
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
    localparam logic [PTR_W:0]   CountOne = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DepthC   = (PTR_W + 1)'(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             sb_err_q, sb_err_d;

    reg_use_t head_use;
    logic     rs_busy, rt_busy, dest_full, hazard;
    logic     push, pop, inc, dec;

    assign out_instr = instr_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_rs    = out_instr[25:21];
    assign out_rt    = out_instr[20:16];

    reg_use_decode u_reg_use_decode (
        .instr (out_instr),
        .use_o (head_use)
    );

    assign out_dest     = head_use.dest;
    assign out_regwrite = head_use.regwrite;

    always_comb begin
        rs_busy = head_use.uses_rs && (out_rs != REG_ZERO) && (cnt_q[out_rs] != '0);
        rt_busy = head_use.uses_rt && (out_rt != REG_ZERO) && (cnt_q[out_rt] != '0);
`ifdef ID_WB_BYPASS_EN
        // Last outstanding write lands this cycle; the regfile forwards it.
        if (wb_valid && wb_addr == out_rs && cnt_q[out_rs] == CntOne) rs_busy = 1'b0;
        if (wb_valid && wb_addr == out_rt && cnt_q[out_rt] == CntOne) rt_busy = 1'b0;
`endif
        dest_full = head_use.regwrite && (out_dest != REG_ZERO) && (cnt_q[out_dest] == CntMax);
        hazard    = rs_busy || rt_busy || dest_full;
    end

    assign count        = count_q;
    assign sb_err       = sb_err_q;
    assign in_ready     = (count_q < DepthC);
    assign out_valid    = (count_q != '0) && !hazard && !flush && !except_flush;
    assign stall_hazard = (count_q != '0) && hazard;

    assign push = in_valid && in_ready && !flush && !except_flush;
    assign pop  = out_valid && out_ready;
    assign inc  = pop && head_use.regwrite && (out_dest != REG_ZERO);
    assign dec  = wb_valid && (wb_addr != REG_ZERO) && (cnt_q[wb_addr] != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        sb_err_d = sb_err_q;
        cnt_d    = cnt_q;
        if (except_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            for (int r = 0; r < 32; r++) cnt_d[r] = '0;
        end else if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            if (push && !pop) count_d = count_q + CountOne;
            if (pop && !push) count_d = count_q - CountOne;
            if (wb_valid && wb_addr != REG_ZERO && cnt_q[wb_addr] == '0) sb_err_d = 1'b1;
            for (int r = 1; r < 32; r++) begin
                if ((inc && out_dest == 5'(r)) && !(dec && wb_addr == 5'(r))) begin
                    cnt_d[r] = cnt_q[r] + CntOne;
                end else if (!(inc && out_dest == 5'(r)) && (dec && wb_addr == 5'(r))) begin
                    cnt_d[r] = cnt_q[r] - CntOne;
                end
            end
            cnt_d[0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sb_err_q <= 1'b0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sb_err_q <= sb_err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed self-checking bench for id_issue_buffer (DEPTH=4, CNT_W=2).
module tb_id_issue_buffer;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [4:0]  out_rs, out_rt, out_dest, wb_addr;
    logic        out_regwrite, wb_valid, flush, except_flush;
    logic [2:0]  count;
    logic        stall_hazard, sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADDU3 = 32'h0022_1821; // addu r3,r1,r2
    localparam logic [31:0] ADDU4 = 32'h0063_2021; // addu r4,r3,r3
    localparam logic [31:0] ADDU5 = 32'h0000_2821; // addu r5,r0,r0
    localparam logic [31:0] ADDI7 = 32'h2407_0001; // addiu r7,r0,1
    localparam logic [31:0] ADDU8 = 32'h00E0_4021; // addu r8,r7,r0

    id_issue_buffer #(.DEPTH(4), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_dest     (out_dest),
        .out_regwrite (out_regwrite),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .except_flush (except_flush),
        .count        (count),
        .stall_hazard (stall_hazard),
        .sb_err       (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic wb(input logic [4:0] addr);
        wb_valid = 1'b1;
        wb_addr  = addr;
        tick();
        wb_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (stall_hazard !== 1'b0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", stall_hazard, sb_err); end
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_order();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(NOP, 32'(4 * i));
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
        push(NOP, 32'h10);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_dropped got %0d exp 4", count); end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
                n_fail++; $display("FAIL order_pc%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 4 * i);
            end
            tick();
        end
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain got cnt=%0d v=%b exp 0 0", count, out_valid); end
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_raw();
        push(ADDU3, 32'h100);
        push(ADDU4, 32'h104);
        n_checks++;
        if (out_valid !== 1'b1 || out_dest !== 5'd3 || out_rs !== 5'd1 || out_rt !== 5'd2 || out_regwrite !== 1'b1) begin
            n_fail++; $display("FAIL raw_head_decode got v=%b d=%0d rs=%0d rt=%0d w=%b exp 1 3 1 2 1", out_valid, out_dest, out_rs, out_rt, out_regwrite);
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (stall_hazard !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall got st=%b v=%b exp 1 0", stall_hazard, out_valid); end
        tick();
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL raw_hold_count got %0d exp 1", count); end
        wb_valid = 1'b1;
        wb_addr  = 5'd3;
        #1;
`ifdef ID_WB_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_valid got %b exp 1", out_valid); end
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_valid got %b exp 0", out_valid); end
`endif
        tick();
        wb_valid = 1'b0;
        #1;
`ifndef ID_WB_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL raw_after_wb got v=%b cnt=%0d exp 1 1", out_valid, count); end
        tick();
`endif
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL raw_issued got %0d exp 0", count); end
        out_ready = 1'b0;
        wb(5'd4);
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL raw_sb_err got %b exp 0", sb_err); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) push(ADDU5, 32'(32'h180 + 4 * i));
        out_ready = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (count !== 3'd1 || stall_hazard !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL sat_stall got cnt=%0d st=%b v=%b exp 1 1 0", count, stall_hazard, out_valid);
        end
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_wb_cycle got %b exp 0", out_valid); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_release got %b exp 1", out_valid); end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL sat_issued got %0d exp 0", count); end
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_flush();
        push(ADDU5, 32'h200);
        push(NOP, 32'h204);
        push(NOP, 32'h208);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        in_valid = 1'b1;
        in_instr = NOP;
        in_pc    = 32'h20C;
        flush    = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gates_valid got %b exp 0", out_valid); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got cnt=%0d rdy=%b exp 0 1", count, in_ready); end
        push(ADDU5, 32'h300);
        n_checks++; if (stall_hazard !== 1'b1) begin n_fail++; $display("FAIL flush_sb_kept got %b exp 1", stall_hazard); end
        wb(5'd5); wb(5'd5); wb(5'd5);
        n_checks++;
        if (stall_hazard !== 1'b0 || out_valid !== 1'b1 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL flush_sb_drained got st=%b v=%b err=%b exp 0 1 0", stall_hazard, out_valid, sb_err);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_except_flush();
        push(ADDI7, 32'h400);
        push(ADDI7, 32'h404);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL exc_pre_issue got %0d exp 0", count); end
        push(ADDU8, 32'h408);
        n_checks++; if (stall_hazard !== 1'b1) begin n_fail++; $display("FAIL exc_r7_pending got %b exp 1", stall_hazard); end
        except_flush = 1'b1;
        wb_valid     = 1'b1;
        wb_addr      = 5'd7;
        tick();
        except_flush = 1'b0;
        wb_valid     = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL exc_clear got cnt=%0d err=%b exp 0 0", count, sb_err); end
        push(ADDU8, 32'h40C);
        n_checks++; if (stall_hazard !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL exc_sb_zeroed got st=%b v=%b exp 0 1", stall_hazard, out_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_sb_err_and_reset();
        wb(5'd9);
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sb_err_set got %b exp 1", sb_err); end
        tick(); tick();
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sb_err_sticky got %b exp 1", sb_err); end
        push(NOP, 32'h500);
        push(NOP, 32'h504);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL pre_rst_count got %0d exp 2", count); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || sb_err !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || stall_hazard !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got cnt=%0d err=%b rdy=%b v=%b st=%b exp 0 0 1 0 0", count, sb_err, in_ready, out_valid, stall_hazard);
        end
        #1 rst = 1'b1;
        tick();
        n_checks++; if (count !== 3'd0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL post_rst got cnt=%0d err=%b exp 0 0", count, sb_err); end
    endtask

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_instr     = '0;
        in_pc        = '0;
        out_ready    = 1'b0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        flush        = 1'b0;
        except_flush = 1'b0;
        test_reset();
        test_fill_order();
        test_raw();
        test_saturation();
        test_flush();
        test_except_flush();
        test_sb_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
